// File: rtl/asic_video_fetcher_if.sv
// Bus bundle between the video fetcher, the SRAM arbiter's video port and the pixel serialiser.
// The master modport is the fetcher; slave is the surrounding arbiter/display side.
interface asic_video_fetcher_if;
  logic        vslot;
  logic        line_start;
  logic [18:0] line_base;
  logic [7:0]  line_len;
  logic [18:0] vramaddr;
  logic [7:0]  data_to_asic;
  logic        fifo_pop;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic [6:0]  fifo_level;
  logic        busy;
  logic        underflow;

  modport master (
    input  vslot, line_start, line_base, line_len, data_to_asic, fifo_pop,
    output vramaddr, fifo_dout, fifo_empty, fifo_level, busy, underflow
  );

  modport slave (
    output vslot, line_start, line_base, line_len, data_to_asic, fifo_pop,
    input  vramaddr, fifo_dout, fifo_empty, fifo_level, busy, underflow
  );
endinterface

// File: rtl/asic_video_fetcher.sv
// Video-side requester: fetches one line of bytes through the arbiter's video slot into a FWFT FIFO.
// Optional sticky pop-on-empty flag enabled by defining VFETCH_UNDERFLOW_EN.
module asic_video_fetcher #(
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 2
) (
  input logic                  clk12,
  input logic                  rst,
  asic_video_fetcher_if.master bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [18:0]           addr_q;
  logic [8:0]            remaining_q;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d, pipe_shift;
  logic [7:0]            mem [DEPTH];
  logic [AW-1:0]         rd_ptr_q, wr_ptr_q, rd_ptr_n;
  logic [6:0]            level_q, level_d, level_after_pop;
  logic [7:0]            dout_q, dout_d;

  logic issue, push, pop, credit_ok;

  // Credit covers bytes already buffered plus those still in the read pipe,
  // so a returning byte always finds room.
  assign credit_ok = (int'(level_q) + $countones(pipe_q)) < DEPTH;
  assign issue     = (state_q == FETCH) && bus.vslot && !bus.line_start && credit_ok;
  assign push      = pipe_q[RD_LATENCY-1] && !bus.line_start;
  assign pop       = bus.fifo_pop && (level_q != 7'd0) && !bus.line_start;

  assign pipe_shift = pipe_q << 1;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pipe_d    = pipe_shift;
    pipe_d[0] = issue;
    if (bus.line_start) pipe_d = '0;

    unique case (state_q)
      IDLE:    state_d = IDLE;
      FETCH:   if (issue && remaining_q == 9'd1) state_d = DRAIN;
      DRAIN:   if (pipe_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.line_start) state_d = FETCH;
  end

  always_comb begin
    level_after_pop = level_q - 7'(pop);
    rd_ptr_n        = rd_ptr_q + AW'(pop);
    level_d         = level_after_pop + 7'(push);
    dout_d          = dout_q;
    if (bus.line_start) begin
      level_d = 7'd0;
    end else if (push && level_after_pop == 7'd0) begin
      dout_d = bus.data_to_asic;
    end else if (level_after_pop != 7'd0) begin
      dout_d = mem[rd_ptr_n];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk12) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 19'd0;
      remaining_q <= 9'd0;
      pipe_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= 7'd0;
      dout_q      <= 8'd0;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
      level_q <= level_d;
      dout_q  <= dout_d;
      if (bus.line_start) begin
        addr_q      <= bus.line_base;
        remaining_q <= (bus.line_len == 8'd0) ? 9'd256 : {1'b0, bus.line_len};
        rd_ptr_q    <= '0;
        wr_ptr_q    <= '0;
      end else begin
        if (issue) begin
          addr_q      <= addr_q + 19'd1;
          remaining_q <= remaining_q - 9'd1;
        end
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        rd_ptr_q <= rd_ptr_n;
      end
    end
  end

  // NOTE: the storage array has no reset; level and pointers alone define which entries are valid.
  always_ff @(posedge clk12) begin
    if (push) mem[wr_ptr_q] <= bus.data_to_asic;
  end

`ifdef VFETCH_UNDERFLOW_EN
  logic underflow_q;
  always_ff @(posedge clk12) begin
    if (rst)                                    underflow_q <= 1'b0;
    else if (bus.fifo_pop && level_q == 7'd0)   underflow_q <= 1'b1;
  end
  assign bus.underflow = underflow_q;
`else
  assign bus.underflow = 1'b0;
`endif

  assign bus.vramaddr   = addr_q;
  assign bus.fifo_dout  = dout_q;
  assign bus.fifo_level = level_q;
  assign bus.fifo_empty = (level_q == 7'd0);
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_asic_video_fetcher.sv
// Directed bench for asic_video_fetcher: SRAM model returns addr[7:0] two edges after the issue edge.
module tb_asic_video_fetcher;
  logic clk12 = 1'b0;
  logic rst   = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   vslot_mode = 0;   // 0: hold low, 1: hold high, 2: toggle

  logic [7:0] sram_d0, sram_d1;

  asic_video_fetcher_if bus ();

  asic_video_fetcher #(.DEPTH(16), .RD_LATENCY(2)) dut (
    .clk12 (clk12),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk12 = ~clk12;

  always @(posedge clk12) begin
    sram_d1 <= sram_d0;
    sram_d0 <= bus.vramaddr[7:0];
  end
  assign bus.data_to_asic = sram_d1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk12);
    bus.line_start = 1'b0;
    bus.fifo_pop   = 1'b0;
    case (vslot_mode)
      0:       bus.vslot = 1'b0;
      1:       bus.vslot = 1'b1;
      default: bus.vslot = ~bus.vslot;
    endcase
  endtask

  task automatic start_line(input logic [18:0] base, input logic [7:0] len);
    bus.line_base  = base;
    bus.line_len   = len;
    bus.line_start = 1'b1;
    step();
  endtask

  task automatic pop_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    while (bus.fifo_empty && n < 50) begin
      step();
      n++;
    end
    if (bus.fifo_empty) check({tag, "_timeout"}, 32'(bus.fifo_empty), 32'd0);
    else begin
      check(tag, 32'(bus.fifo_dout), 32'(exp));
      bus.fifo_pop = 1'b1;
      step();
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    check(tag, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [18:0] prev_addr, a0;
    int cyc, last_issue, changes;
    logic [7:0] b;

    bus.vslot      = 1'b0;
    bus.line_start = 1'b0;
    bus.line_base  = 19'd0;
    bus.line_len   = 8'd0;
    bus.fifo_pop   = 1'b0;
    sram_d0 = 8'd0;
    sram_d1 = 8'd0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_vramaddr", 32'(bus.vramaddr), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_level", 32'(bus.fifo_level), 32'd0);
    check("rst_empty", 32'(bus.fifo_empty), 32'd1);
    check("rst_dout", 32'(bus.fifo_dout), 32'd0);
    check("rst_underflow", 32'(bus.underflow), 32'd0);

    // 1: four-byte line, toggling slot
    vslot_mode = 2;
    start_line(19'h01000, 8'd4);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_base", 32'(bus.vramaddr), 32'h01000);
    prev_addr = bus.vramaddr;
    cyc = 0;
    last_issue = 0;
    while (bus.busy && cyc < 60) begin
      step();
      cyc++;
      if (bus.vramaddr != prev_addr) begin
        last_issue = cyc;
        prev_addr  = bus.vramaddr;
      end
    end
    check("t1_idle", 32'(bus.busy), 32'd0);
    check("t1_busy_fall", 32'(cyc - last_issue), 32'd2);
    check("t1_vramaddr", 32'(bus.vramaddr), 32'h01004);
    check("t1_level", 32'(bus.fifo_level), 32'd4);
    for (int i = 0; i < 4; i++) pop_byte("t1_data", 8'(i));
    check("t1_empty", 32'(bus.fifo_empty), 32'd1);

    // 5a: pop on empty in IDLE
    b = bus.fifo_dout;
    bus.fifo_pop = 1'b1;
    step();
    check("t5_empty_level", 32'(bus.fifo_level), 32'd0);
    check("t5_empty_dout", 32'(bus.fifo_dout), 32'(b));
`ifdef VFETCH_UNDERFLOW_EN
    check("t5_underflow", 32'(bus.underflow), 32'd1);
`else
    check("t5_underflow", 32'(bus.underflow), 32'd0);
`endif

    // 2: 256-byte line, credit stall at DEPTH
    start_line(19'h00000, 8'd0);
    repeat (100) step();
    check("t2_level_full", 32'(bus.fifo_level), 32'd16);
    check("t2_issued", 32'(bus.vramaddr), 32'h00010);
    check("t2_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 256; i++) pop_byte("t2_data", 8'(i));
    wait_idle("t2_idle");
    check("t2_vramaddr", 32'(bus.vramaddr), 32'h00100);
    check("t2_level_end", 32'(bus.fifo_level), 32'd0);

    // 3: address wrap at the top of the 19-bit space
    start_line(19'h7FFFE, 8'd4);
    wait_idle("t3_idle");
    check("t3_vramaddr", 32'(bus.vramaddr), 32'h00002);
    pop_byte("t3_d0", 8'hFE);
    pop_byte("t3_d1", 8'hFF);
    pop_byte("t3_d2", 8'h00);
    pop_byte("t3_d3", 8'h01);

    // 4: restart with two reads in flight
    vslot_mode = 1;
    start_line(19'h10040, 8'd20);
    step();
    step();
    check("t4_two_issued", 32'(bus.vramaddr), 32'h10042);
    start_line(19'h20000, 8'd4);
    check("t4_flush_level", 32'(bus.fifo_level), 32'd0);
    check("t4_new_base", 32'(bus.vramaddr), 32'h20000);
    for (int i = 0; i < 4; i++) pop_byte("t4_data", 8'(i));
    wait_idle("t4_idle");
    check("t4_level_end", 32'(bus.fifo_level), 32'd0);

    // 5b: simultaneous push and pop at level 5
    start_line(19'h04000, 8'd8);
    cyc = 0;
    while (bus.fifo_level != 7'd5 && cyc < 50) begin
      step();
      cyc++;
    end
    check("t5_reach5", 32'(bus.fifo_level), 32'd5);
    check("t5_head", 32'(bus.fifo_dout), 32'h00);
    bus.fifo_pop = 1'b1;
    step();
    check("t5_pushpop_level", 32'(bus.fifo_level), 32'd5);
    for (int i = 1; i < 8; i++) pop_byte("t5_data", 8'(i));
    wait_idle("t5_idle");

    // 6: slot withheld mid-line
    vslot_mode = 2;
    start_line(19'h03000, 8'd8);
    repeat (3) step();
    vslot_mode = 0;
    step();
    a0 = bus.vramaddr;
    changes = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.vramaddr != a0) changes++;
    end
    check("t6_stable", 32'(changes), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd1);
    vslot_mode = 1;
    step();
    step();
    check("t6_resume", 32'(bus.vramaddr), 32'(a0 + 19'd1));
    for (int i = 0; i < 8; i++) pop_byte("t6_data", 8'(i));
    wait_idle("t6_idle");
    check("t6_vramaddr", 32'(bus.vramaddr), 32'h03008);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
